spi_peripheral: RTL and testbench

//  SPI target endpoint downstream of the SPI controller: consumes p_clk/p_sel_n/copi, returns cipo.

---
 rtl/spi_peripheral.sv | 139 +++++++++++++
 tb/tb_spi_peripheral.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: oversampled SPI target, LSB-first, one word per select; define SPI_PERI_OVERRUN_EN to drop words arriving while rx_valid is pending
module spi_peripheral #(
  parameter int SPI_DATA_WIDTH = 8,
  parameter bit CPOL = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      sys_clk,
  input  logic                      sync_rst_n,
  input  logic                      sys_clk_en,
  input  logic                      p_clk,
  input  logic                      p_sel_n,
  input  logic                      copi,
  output logic                      cipo,
  input  logic [SPI_DATA_WIDTH-1:0] tx_data,
  input  logic                      tx_load,
  output logic                      tx_ready,
  output logic [SPI_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ack,
  output logic                      rx_overrun,
  output logic                      busy
);
  localparam int W = SPI_DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] clk_sync, sel_sync, copi_sync;
  logic clk_q, sel_q, dlv, shadow_full;
  logic [W-1:0] shadow, tx_shift, rx_shift, tx_next;
  logic [CW-1:0] bit_cnt;
  logic clk_s, sel_s, copi_s, lead, trail, sel_fall, sel_rise, load_ok, consume;
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign sel_s = sel_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign lead = (clk_q == CPOL) && (clk_s != CPOL);
  assign trail = (clk_q != CPOL) && (clk_s == CPOL);
  assign sel_fall = sel_q & ~sel_s;
  assign sel_rise = ~sel_q & sel_s;
  assign load_ok = tx_load & ~shadow_full;
  assign consume = (state == IDLE) & sel_fall;
  assign tx_next = tx_shift >> 1;
  assign tx_ready = ~shadow_full;
  assign busy = (state != IDLE);
  // pin synchronizers plus one-cycle history for edge detection
  always_ff @(posedge sys_clk)
    if (!sync_rst_n) begin
      clk_sync <= {SYNC_STAGES{CPOL}};
      sel_sync <= '1;
      copi_sync <= '0;
      clk_q <= CPOL;
      sel_q <= 1'b1;
    end else if (sys_clk_en) begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], p_clk};
      sel_sync <= {sel_sync[SYNC_STAGES-2:0], p_sel_n};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      clk_q <= clk_s;
      sel_q <= sel_s;
    end
  // select-window FSM: shifts rx on lead edges, tx on trail edges, flags delivery after the last bit
  always_ff @(posedge sys_clk)
    if (!sync_rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      cipo <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      dlv <= 1'b0;
    end else if (sys_clk_en) begin
      dlv <= 1'b0;
      case (state)
        IDLE: begin
          cipo <= 1'b0;
          bit_cnt <= '0;
          if (sel_fall) begin
            state <= ACTIVE;
            tx_shift <= shadow_full ? shadow : '0;
            cipo <= shadow_full & shadow[0];
          end
        end
        ACTIVE:
          if (sel_rise) begin
            state <= IDLE;
            bit_cnt <= '0;
            cipo <= 1'b0;
          end else if (lead) begin
            rx_shift <= {copi_s, rx_shift[W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST) begin
              state <= DONE;
              dlv <= 1'b1;
            end
          end else if (trail) begin
            tx_shift <= tx_next;
            cipo <= tx_next[0];
          end
        DONE:
          if (sel_rise) begin
            state <= IDLE;
            bit_cnt <= '0;
            cipo <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  // one-entry reply shadow: a select empties it, a load into an empty shadow on the same edge still lands
  always_ff @(posedge sys_clk)
    if (!sync_rst_n) begin
      shadow_full <= 1'b0;
      shadow <= '0;
    end else if (sys_clk_en) begin
      shadow_full <= load_ok | (shadow_full & ~consume);
      shadow <= load_ok ? tx_data : shadow;
    end
`ifdef SPI_PERI_OVERRUN_EN
  // receive handshake: a word arriving while the previous one is unacknowledged is dropped and flagged
  always_ff @(posedge sys_clk)
    if (!sync_rst_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (sys_clk_en) begin
      rx_data <= (dlv && (!rx_valid || rx_ack)) ? rx_shift : rx_data;
      rx_valid <= dlv | (rx_valid & ~rx_ack);
      rx_overrun <= ~rx_ack & (rx_overrun | (dlv & rx_valid));
    end
`else
  // receive handshake: every completed word overwrites rx_data
  always_ff @(posedge sys_clk)
    if (!sync_rst_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else if (sys_clk_en) begin
      rx_data <= dlv ? rx_shift : rx_data;
      rx_valid <= dlv | (rx_valid & ~rx_ack);
    end
  assign rx_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: randomized word-level SPI controller checked against a transaction model
module tb_spi_peripheral;
  localparam bit CPOL = 1'b0;
  localparam int H = 12;
`ifdef SPI_PERI_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif
  logic sys_clk, sync_rst_n, sys_clk_en, p_clk, p_sel_n, copi, cipo;
  logic [7:0] tx_data, rx_data;
  logic tx_load, tx_ready, rx_valid, rx_ack, rx_overrun, busy;
  int vectors = 0, errors = 0, cyc = 0;
  bit force_en, chk_en;
  logic [7:0] m_data, m_shadow, cap;
  bit m_valid, m_overrun, m_full, m_busy;
  spi_peripheral #(.SPI_DATA_WIDTH(8), .CPOL(CPOL), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sync_rst_n(sync_rst_n), .sys_clk_en(sys_clk_en),
    .p_clk(p_clk), .p_sel_n(p_sel_n), .copi(copi), .cipo(cipo),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .busy(busy)
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge sys_clk)
    if (chk_en) begin
      chk("rx_data", rx_data, m_data);
      chk("rx_valid", rx_valid, m_valid);
      chk("rx_overrun", rx_overrun, m_overrun);
      chk("tx_ready", tx_ready, !m_full);
      chk("busy", busy, m_busy);
      if (!m_busy) chk("cipo_idle", cipo, 0);
    end
  task automatic tick;
    @(posedge sys_clk);
    #1;
    cyc++;
    sys_clk_en = force_en || cyc[0] || ($urandom_range(0, 3) != 0);
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick;
  endtask
  task automatic ld(input logic [7:0] w);
    tx_data = w;
    tx_load = 1'b1;
    sys_clk_en = 1'b1;
    tick;
    tx_load = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_shadow = w;
    end
  endtask
  task automatic ack;
    rx_ack = 1'b1;
    sys_clk_en = 1'b1;
    tick;
    rx_ack = 1'b0;
    m_valid = 1'b0;
    m_overrun = 1'b0;
  endtask
  task automatic deliver(input logic [7:0] w, input bit with_ack);
    if (with_ack || !m_valid || !OVR) begin
      m_data = w;
      m_valid = 1'b1;
      m_overrun = 1'b0;
    end else m_overrun = 1'b1;
  endtask
  // mode 0: free-running enable; 1: exact timing, checks delivery latency; 2: exact timing, ack on the delivery cycle
  task automatic xfer(input logic [7:0] w, input int nb, input int mode, input bit lds, input logic [7:0] ldw);
    logic [7:0] exp_tx;
    exp_tx = m_full ? m_shadow : 8'h00;
    chk_en = 1'b0;
    cap = 8'h00;
    if (lds) begin
      force_en = 1'b1;
      sys_clk_en = 1'b1;
    end
    copi = w[0];
    p_sel_n = 1'b0;
    if (lds) begin
      ticks(2);
      tx_data = ldw;
      tx_load = 1'b1;
      tick;
      tx_load = 1'b0;
      force_en = 1'b0;
    end
    ticks(lds ? H - 3 : H);
    if (lds && !m_full) begin
      m_full = 1'b1;
      m_shadow = ldw;
    end else m_full = 1'b0;
    m_busy = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < nb; i++) begin
      cap[i] = cipo;
      chk($sformatf("cipo_bit%0d", i), cipo, exp_tx[i]);
      if (i == 7) begin
        chk_en = 1'b0;
        if (mode != 0) begin
          force_en = 1'b1;
          sys_clk_en = 1'b1;
        end
        p_clk = ~CPOL;
        if (mode == 0) ticks(H);
        else begin
          ticks(3);
          if (mode == 1) chk("lat_early", rx_valid, m_valid);
          rx_ack = (mode == 2);
          tick;
          rx_ack = 1'b0;
          if (mode == 1) chk("lat_valid", rx_valid, 1);
        end
        deliver(w, mode == 2);
        chk_en = 1'b1;
        ticks(H);
        p_clk = CPOL;
        ticks(H);
      end else begin
        p_clk = ~CPOL;
        ticks(H);
        p_clk = CPOL;
        copi = w[i+1];
        ticks(H);
      end
    end
    chk_en = 1'b0;
    p_sel_n = 1'b1;
    ticks(H);
    m_busy = 1'b0;
    force_en = 1'b0;
    chk_en = 1'b1;
  endtask
  initial begin
    chk_en = 1'b0;
    force_en = 1'b1;
    sync_rst_n = 1'b0;
    sys_clk_en = 1'b1;
    p_clk = CPOL;
    p_sel_n = 1'b1;
    copi = 1'b0;
    tx_data = 8'h00;
    tx_load = 1'b0;
    rx_ack = 1'b0;
    {m_data, m_shadow, m_valid, m_overrun, m_full, m_busy} = '0;
    ticks(3);
    chk("rst_cipo", cipo, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_busy", busy, 0);
    sync_rst_n = 1'b1;
    force_en = 1'b0;
    tick;
    chk_en = 1'b1;
    ld(8'h3C);
    xfer(8'hA5, 8, 1, 1'b0, 8'h00);
    chk("t1_cipo", cap, 8'h3C);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_rx_valid", rx_valid, 1);
    chk("t1_busy", busy, 0);
    ack;
    xfer(8'h96, 8, 0, 1'b0, 8'h00);
    chk("t2_cipo", cap, 8'h00);
    chk("t2_tx_ready", tx_ready, 1);
    ack;
    xfer(8'h11, 8, 0, 1'b0, 8'h00);
    xfer(8'h22, 8, 0, 1'b0, 8'h00);
    chk("t3_rx_data", rx_data, OVR ? 8'h11 : 8'h22);
    chk("t3_overrun", rx_overrun, OVR ? 1 : 0);
    ack;
    ld(8'hC3);
    xfer(8'hFF, 4, 0, 1'b0, 8'h00);
    chk("t4_rx_valid", rx_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_tx_ready", tx_ready, 1);
    chk("t4_cipo_part", cap, 8'h03);
    xfer(8'h5A, 8, 0, 1'b0, 8'h00);
    chk("t4_rx_data", rx_data, 8'h5A);
    xfer(8'h77, 8, 2, 1'b0, 8'h00);
    chk("t5_rx_valid", rx_valid, 1);
    chk("t5_rx_data", rx_data, 8'h77);
    chk("t5_overrun", rx_overrun, 0);
    ack;
    xfer(8'h33, 8, 0, 1'b1, 8'hE7);
    chk("ls_cipo", cap, 8'h00);
    chk("ls_tx_ready", tx_ready, 0);
    xfer(8'h44, 8, 0, 1'b0, 8'h00);
    chk("ls_cipo_next", cap, 8'hE7);
    repeat (24) begin
      if ($urandom_range(0, 1) == 1) ld(8'($urandom));
      if ($urandom_range(0, 3) == 0) ld(8'($urandom));
      if ($urandom_range(0, 2) == 0) ack;
      xfer(8'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8, 0, 1'b0, 8'h00);
    end
    xfer(8'h9C, 8, 0, 1'b0, 8'h00);
    chk_en = 1'b0;
    p_sel_n = 1'b0;
    copi = 1'b1;
    ticks(H);
    ld(8'h0F);
    p_clk = ~CPOL;
    ticks(H);
    p_clk = CPOL;
    ticks(H);
    p_clk = ~CPOL;
    ticks(5);
    sync_rst_n = 1'b0;
    sys_clk_en = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("t6_cipo", cipo, 0);
    chk("t6_tx_ready", tx_ready, 1);
    chk("t6_rx_data", rx_data, 0);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_overrun", rx_overrun, 0);
    chk("t6_busy", busy, 0);
    p_sel_n = 1'b1;
    p_clk = CPOL;
    sync_rst_n = 1'b1;
    {m_data, m_shadow, m_valid, m_overrun, m_full, m_busy} = '0;
    ticks(H);
    chk_en = 1'b1;
    ticks(H);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
